fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DSIZE, default 8, width of each data word and of wdata.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..4.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant; legal range 1..15.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port wclk, input, 1, write-domain clock; all state updates on its rising edge.
REQ-006 Port wrst_n, input, 1, asynchronous active-low reset.
REQ-007 Port req_valid, input, NREQ, per-requester "data available".
REQ-008 Port req_data, input, NREQ*DSIZE, requester k data in bits [k*DSIZE +: DSIZE].
REQ-009 Port req_ready, output, NREQ, per-requester "beat accepted this cycle".
REQ-010 Port wfull, input, 1, FIFO write-side full flag.
REQ-011 Port winc, output, 1, FIFO write enable.
REQ-012 Port wdata, output, DSIZE, FIFO write data.
REQ-013 Port grant_id, output, 2, index of the current owner; 0 when not in GRANT.
REQ-014 Port busy, output, 1, high while in GRANT.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-016 Registered state: state, owner (2 b), rr_ptr (2 b), burst_cnt (4 b).
REQ-017 IDLE with any req_valid high: owner <= first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ; burst_cnt <= 0; go to GRANT.
REQ-018 IDLE with req_valid all 0: stay in IDLE; no state change.
REQ-019 In GRANT, xfer = req_valid[owner] & ~wfull, combinational.
REQ-020 winc = xfer; req_ready[owner] = xfer; every other req_ready bit = 0; wdata = req_data[owner] in GRANT, else 0.
REQ-021 A beat transfers on the wclk edge where xfer=1; on that edge burst_cnt <= burst_cnt+1.
REQ-022 wfull=1 in GRANT: winc=0, req_ready=0, burst_cnt holds, owner holds; stay in GRANT (stall, no timeout).
REQ-023 GRANT to IDLE when xfer=1 and burst_cnt = MAX_BURST-1 (last beat); rr_ptr <= (owner+1) mod NREQ.
REQ-024 GRANT to IDLE when req_valid[owner]=0 (early end, no transfer that cycle); rr_ptr <= (owner+1) mod NREQ.
REQ-025 When wfull=1 and req_valid[owner]=0 in the same cycle, REQ-024 applies.
REQ-026 Latency: first beat at the earliest one cycle after the IDLE arbitration cycle; one IDLE cycle between consecutive grants.
REQ-027 A requester that is not the owner is never acknowledged, and its req_valid has no effect until the next arbitration.
REQ-028 rr_ptr arithmetic wraps modulo NREQ; (NREQ-1)+1 gives 0.
REQ-029 The block SHALL NOT write when wfull=1, so no beat is ever lost or duplicated.

Reset
REQ-030 When wrst_n=0, the block SHALL immediately, without waiting for a clock edge, set state=IDLE, owner=0, rr_ptr=0 and burst_cnt=0.
REQ-031 During reset all outputs SHALL be 0: winc, req_ready, wdata, grant_id and busy.
REQ-032 Reset asserted mid-burst abandons the burst; after release, arbitration restarts from requester 0.
REQ-033 The first arbitration may occur on the first wclk rising edge after wrst_n rises.

Verification
REQ-034 Single-requester burst: requester 1 presents 0x11, 0x22, 0x33, then drops valid; wfull=0 -> 1 arbitration cycle, then winc=1 for 3 cycles with wdata 0x11/0x22/0x33 and grant_id=1, then IDLE with busy=0.
REQ-035 All four requesters continuously valid, MAX_BURST=4 -> grant sequence 0,1,2,3,0; exactly 4 winc pulses per grant; exactly 1 idle cycle between grants.
REQ-036 Requester 0 mid-burst after 2 beats, wfull held high for 5 cycles -> winc=0 and req_ready=0 for those 5 cycles; then 2 more beats; total 4 beats for the grant.
REQ-037 Requester 2 drops valid after 2 beats while requesters 0 and 3 are valid -> return to IDLE; the next grant goes to 3, not 0.
REQ-038 wrst_n pulsed low mid-burst at a non-edge time -> all outputs 0 within the same timestep; after release with all requests valid, the first grant goes to 0.
REQ-039 Integration with the 8-deep async FIFO (wclk 10 ns, rclk 20 ns): requesters 0 and 1 write 11 words in total with reads enabled -> the read-back sequence equals the write order in grant order, with no loss, no duplicates, and no write while wfull=1.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the requesters, the write arbiter and the FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [1:0]            grant_id;
    logic                  busy;

    // arbiter side
    modport master (
        input  req_valid, req_data, wfull,
        output req_ready, winc, wdata, grant_id, busy
    );

    // requester / FIFO side
    modport slave (
        output req_valid, req_data, wfull,
        input  req_ready, winc, wdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that merges up to four requesters onto one FIFO write port.
//
// state | meaning
// IDLE  | no owner; arbitrates among valid requesters starting at rr_ptr
// GRANT | owner streams beats while valid and FIFO not full, up to MAX_BURST
module fifo_wr_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    fifo_wr_arbiter_if.master     bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;

    // Requests are widened to four slots so a 2-bit owner can index them for any NREQ.
    logic [3:0]       valid4;
    logic [DSIZE-1:0] data4 [4];
    logic             found;
    logic [1:0]       pick;
    logic [2:0]       cand;
    logic [1:0]       next_ptr;
    logic             owner_valid;
    logic             xfer;
    logic [3:0]       ready4;

    // Widen requests, select the owner's lane and find the next round-robin winner.
    always_comb begin
        valid4 = 4'(bus.req_valid);
        for (int k = 0; k < 4; k++) begin
            data4[k] = '0;
        end
        for (int k = 0; k < NREQ; k++) begin
            data4[k] = bus.req_data[k*DSIZE +: DSIZE];
        end
        owner_valid = valid4[owner_q];

        found = 1'b0;
        pick  = 2'd0;
        cand  = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + 3'(i);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!found && valid4[cand[1:0]]) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end

        if ({1'b0, owner_q} == 3'(NREQ - 1)) begin
            next_ptr = 2'd0;
        end else begin
            next_ptr = owner_q + 2'd1;
        end
    end

    // Next-state logic and handshake outputs; outputs are all zero outside GRANT.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        xfer         = 1'b0;
        ready4       = 4'd0;
        bus.winc     = 1'b0;
        bus.wdata    = '0;
        bus.grant_id = 2'd0;
        bus.busy     = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d     = pick;
                    burst_cnt_d = 4'd0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                xfer           = owner_valid & ~bus.wfull;
                ready4[owner_q] = xfer;
                bus.winc       = xfer;
                bus.wdata      = data4[owner_q];
                bus.grant_id   = owner_q;
                bus.busy       = 1'b1;
                // A dropped valid ends the grant even during a full stall.
                if (!owner_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q == 4'(MAX_BURST - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bus.req_ready = ready4[NREQ-1:0];
    end

    // State register with asynchronous reset back to IDLE, pointer at requester 0.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            rr_ptr_q    <= 2'd0;
            burst_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle expectation queue plus FIFO read-order scoreboard.
module tb_fifo_wr_arbiter;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b1;

    fifo_wr_arbiter_if #(.DSIZE(8), .NREQ(4)) bus ();

    fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .MAX_BURST(4)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    // clock generation, 10 ns period
    always #5 wclk = ~wclk;

    typedef struct packed {
        logic       busy;
        logic [1:0] gid;
        logic       winc;
        logic [7:0] wdata;
    } exp_t;

    int         checks   = 0;
    int         failures = 0;
    exp_t       cyc_q [$];
    logic [7:0] rd_exp [$];
    logic [7:0] fifo_m [$];
    logic [7:0] src [4][$];
    logic [3:0] src_en   = 4'd0;
    logic       fifo_on  = 1'b0;
    int         cyc_n    = 0;
    int         writes_n = 0;
    int         taken [4];
    int         order [5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            bus.req_valid[k]       = src_en[k] && (src[k].size() > 0);
            bus.req_data[k*8 +: 8] = (src[k].size() > 0) ? src[k][0] : 8'h00;
        end
    endtask

    task automatic clear_src();
        for (int k = 0; k < 4; k++) src[k].delete();
        src_en = 4'd0;
        drive();
    endtask

    task automatic ex(input logic b, input logic [1:0] g, input logic w, input logic [7:0] d);
        exp_t e;
        e.busy = b; e.gid = g; e.winc = w; e.wdata = d;
        cyc_q.push_back(e);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},  bus.busy,      0);
        chk({tag, "_winc"},  bus.winc,      0);
        chk({tag, "_gid"},   bus.grant_id,  0);
        chk({tag, "_wdata"}, bus.wdata,     0);
        chk({tag, "_ready"}, bus.req_ready, 0);
    endtask

    // One clock cycle: sample at negedge, then apply source/FIFO side effects after posedge.
    task automatic tick();
        logic       s_winc, s_busy;
        logic [1:0] s_gid;
        logic [7:0] s_wdata, rd;
        logic [3:0] s_ready, e_ready;
        exp_t       e;
        @(negedge wclk);
        s_winc = bus.winc; s_busy = bus.busy; s_gid = bus.grant_id;
        s_wdata = bus.wdata; s_ready = bus.req_ready;
        chk("no_write_when_full", 32'(s_winc && bus.wfull), 0);
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            e_ready = e.winc ? (4'd1 << e.gid) : 4'd0;
            chk("busy",      s_busy,  e.busy);
            chk("grant_id",  s_gid,   e.gid);
            chk("winc",      s_winc,  e.winc);
            chk("wdata",     s_wdata, e.wdata);
            chk("req_ready", s_ready, e_ready);
        end
        @(posedge wclk);
        #1;
        if (fifo_on) begin
            cyc_n++;
            if (cyc_n[0] && fifo_m.size() > 0) begin
                rd = fifo_m.pop_front();
                if (rd_exp.size() > 0) chk("read_order", rd, rd_exp.pop_front());
                else chk("read_extra", rd_exp.size(), 1);
            end
            if (s_winc) begin
                fifo_m.push_back(s_wdata);
                writes_n++;
            end
            bus.wfull = (fifo_m.size() >= 8);
        end
        for (int k = 0; k < 4; k++) begin
            if (s_ready[k] && src[k].size() > 0) void'(src[k].pop_front());
        end
        drive();
    endtask

    task automatic do_reset(input string tag);
        wrst_n = 1'b0;
        #1;
        chk_zero_outputs(tag);
        @(posedge wclk);
        #2;
        wrst_n = 1'b1;
    endtask

    initial begin
        bus.wfull = 1'b0;
        clear_src();
        do_reset("por");

        // single requester burst of three words, early end
        src[1].push_back(8'h11); src[1].push_back(8'h22); src[1].push_back(8'h33);
        src_en = 4'b0010; drive();
        ex(0, 0, 0, 8'h00);
        ex(1, 1, 1, 8'h11); ex(1, 1, 1, 8'h22); ex(1, 1, 1, 8'h33);
        ex(1, 1, 0, 8'h00);
        ex(0, 0, 0, 8'h00);
        repeat (6) tick();

        // all four continuously valid: grants 0,1,2,3,0 of 4 beats each
        clear_src();
        do_reset("rst2");
        for (int k = 0; k < 4; k++) begin
            taken[k] = 0;
            for (int j = 0; j < 8; j++) src[k].push_back(8'(8'h40 + k*16 + j));
        end
        src_en = 4'b1111; drive();
        for (int g = 0; g < 5; g++) begin
            ex(0, 0, 0, 8'h00);
            for (int b = 0; b < 4; b++) begin
                ex(1, 2'(order[g]), 1, 8'(8'h40 + order[g]*16 + taken[order[g]]));
                taken[order[g]]++;
            end
        end
        ex(0, 0, 0, 8'h00);
        repeat (25) tick();
        src_en = 4'd0; drive();
        tick();

        // requester 0 stalled by wfull for 5 cycles after 2 beats
        clear_src();
        do_reset("rst3");
        for (int j = 0; j < 6; j++) src[0].push_back(8'(8'hA0 + j));
        src_en = 4'b0001; drive();
        ex(0, 0, 0, 8'h00); ex(1, 0, 1, 8'hA0); ex(1, 0, 1, 8'hA1);
        repeat (5) ex(1, 0, 0, 8'hA2);
        ex(1, 0, 1, 8'hA2); ex(1, 0, 1, 8'hA3);
        ex(0, 0, 0, 8'h00);
        repeat (3) tick();
        bus.wfull = 1'b1;
        repeat (5) tick();
        bus.wfull = 1'b0;
        repeat (2) tick();
        src_en = 4'd0; drive();
        tick();

        // requester 2 drops early while 0 and 3 wait: next grants 3 then 0
        clear_src();
        src[0].push_back(8'hC0);
        src[2].push_back(8'hE0); src[2].push_back(8'hE1);
        src[3].push_back(8'hF0);
        src_en = 4'b1101; drive();
        ex(0, 0, 0, 8'h00); ex(1, 2, 1, 8'hE0); ex(1, 2, 1, 8'hE1); ex(1, 2, 0, 8'h00);
        ex(0, 0, 0, 8'h00); ex(1, 3, 1, 8'hF0); ex(1, 3, 0, 8'h00);
        ex(0, 0, 0, 8'h00); ex(1, 0, 1, 8'hC0); ex(1, 0, 0, 8'h00);
        ex(0, 0, 0, 8'h00);
        repeat (11) tick();

        // asynchronous reset mid-burst, then arbitration restarts at requester 0
        clear_src();
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++) src[k].push_back(8'(8'h80 + k*16 + j));
        src_en = 4'b1111; drive();
        ex(0, 0, 0, 8'h00); ex(1, 1, 1, 8'h90); ex(1, 1, 1, 8'h91);
        repeat (3) tick();
        #3;
        do_reset("mid_rst");
        ex(0, 0, 0, 8'h00);
        ex(1, 0, 1, 8'h80); ex(1, 0, 1, 8'h81); ex(1, 0, 1, 8'h82); ex(1, 0, 1, 8'h83);
        ex(0, 0, 0, 8'h00);
        repeat (5) tick();
        src_en = 4'd0; drive();
        tick();
        chk("cyc_q_drained", cyc_q.size(), 0);

        // two requesters into an 8-deep FIFO read every other cycle
        clear_src();
        do_reset("rst6");
        for (int j = 0; j < 6; j++) src[0].push_back(8'(8'hD0 + j));
        for (int j = 0; j < 5; j++) src[1].push_back(8'(8'h30 + j));
        for (int j = 0; j < 4; j++) rd_exp.push_back(8'(8'hD0 + j));
        for (int j = 0; j < 4; j++) rd_exp.push_back(8'(8'h30 + j));
        rd_exp.push_back(8'hD4); rd_exp.push_back(8'hD5); rd_exp.push_back(8'h34);
        fifo_on = 1'b1; cyc_n = 0; writes_n = 0;
        src_en = 4'b0011; drive();
        for (int t = 0; t < 400 && rd_exp.size() > 0; t++) tick();
        chk("read_all",      rd_exp.size(), 0);
        chk("write_count",   writes_n,      11);
        chk("fifo_drained",  fifo_m.size(), 0);
        fifo_on = 1'b0;
        bus.wfull = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
